// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller bundle: raw button
// levels in, BCD display word and status out.
interface stopwatch_ctrl_if;
  logic        btn_start_stop;
  logic        btn_reset;
  logic        btn_lap;
  logic [15:0] disp_bcd;
  logic        running;
  logic        lap_active;
  logic        overflow;
  logic        tick;

  modport master (
    output btn_start_stop,
    output btn_reset,
    output btn_lap,
    input  disp_bcd,
    input  running,
    input  lap_active,
    input  overflow,
    input  tick
  );

  modport slave (
    input  btn_start_stop,
    input  btn_reset,
    input  btn_lap,
    output disp_bcd,
    output running,
    output lap_active,
    output overflow,
    output tick
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: SS.cc BCD count with
// IDLE/RUN/PAUSE/LAP control and 100 Hz prescaler.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 1000000,
  parameter int CNT_W    = 20
) (
  input logic            clk,
  input logic            clr,
  stopwatch_ctrl_if.slave sw
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    LAP
  } state_t;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TICK_DIV - 1);

  // bit order: {start_stop, reset, lap}
  logic [2:0] s1, s2, prev;
  logic [2:0] ev;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [15:0] snap, snap_n;
  logic [CNT_W-1:0] pre, pre_n;
  logic        ovf, ovf_n;
  logic        tick_now;
  logic        counting;
  logic [15:0] disp;
  logic        run_q, lap_q;

  // one-cycle BCD increment with full ripple
  function automatic logic [15:0] bcd_inc(
    input logic [15:0] v
  );
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd9) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (v[11:8] != 4'd9) begin
          r[11:8] = v[11:8] + 4'd1;
        end else begin
          r[11:8]  = 4'd0;
          r[15:12] = v[15:12] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  // synchronize buttons and keep previous level
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= {sw.btn_start_stop,
               sw.btn_reset,
               sw.btn_lap};
      s2   <= s1;
      prev <= s2;
    end
  end

  assign ev = s2 & ~prev;

  assign counting = (state == RUN) ||
                    (state == LAP);
  assign tick_now = counting && (pre == LAST);

  // state, count, snapshot and prescaler registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
      snap  <= '0;
      pre   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      snap  <= snap_n;
      pre   <= pre_n;
      ovf   <= ovf_n;
    end
  end

  // event arbitration, counting and saturation
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    snap_n  = snap;
    pre_n   = pre;
    ovf_n   = ovf;
    if (counting) begin
      pre_n = tick_now ? '0 : pre + 1'b1;
    end
    unique case (state)
      IDLE: begin
        if (ev[1]) begin
          cnt_n = '0;
          pre_n = '0;
        end else if (ev[2]) begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (ev[2]) begin
          state_n = PAUSE;
        end else if (ev[0]) begin
          snap_n  = cnt;
          state_n = LAP;
        end
      end
      LAP: begin
        if (ev[2]) begin
          state_n = PAUSE;
        end else if (ev[0]) begin
          state_n = RUN;
        end
      end
      PAUSE: begin
        if (ev[1]) begin
          cnt_n   = '0;
          pre_n   = '0;
          ovf_n   = 1'b0;
          state_n = IDLE;
        end else if (ev[2] && !ovf) begin
          state_n = RUN;
        end
      end
      default: state_n = IDLE;
    endcase
    if (tick_now) begin
      if (cnt == 16'h9999) begin
        ovf_n   = 1'b1;
        state_n = PAUSE;
      end else begin
        cnt_n = bcd_inc(cnt);
      end
    end
  end

  // display word and status decodes
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      disp  <= '0;
      run_q <= 1'b0;
      lap_q <= 1'b0;
    end else begin
      disp  <= (state == LAP) ? snap : cnt;
      run_q <= (state_n == RUN) ||
               (state_n == LAP);
      lap_q <= (state_n == LAP);
    end
  end

  assign sw.disp_bcd   = disp;
  assign sw.running    = run_q;
  assign sw.lap_active = lap_q;
  assign sw.overflow   = ovf;
  assign sw.tick       = tick_now;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a
// fast prescaler (4 clocks per centisecond).
module tb_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic clr;

  stopwatch_ctrl_if sw ();

  stopwatch_ctrl #(
    .TICK_DIV(TD),
    .CNT_W   (CW)
  ) dut (
    .clk(clk),
    .clr(clr),
    .sw (sw)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ss;
    logic        rst;
    logic        lap;
    int          w;
    logic [15:0] disp;
    logic        run;
    logic        lapa;
    logic        ovf;
  } vec_t;

  vec_t tbl [12];
  int n_cmp = 0;
  int n_bad = 0;
  int tk;

  task automatic chk(input string nm,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               nm, got, exp);
    end
  endtask

  task automatic press(input logic ss,
                       input logic rst,
                       input logic lap);
    @(posedge clk);
    #1;
    sw.btn_start_stop = ss;
    sw.btn_reset      = rst;
    sw.btn_lap        = lap;
    @(posedge clk);
    @(posedge clk);
    #1;
    sw.btn_start_stop = 1'b0;
    sw.btn_reset      = 1'b0;
    sw.btn_lap        = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int seen;
    int cyc;
    seen = 0;
    cyc  = 0;
    while (seen < n && cyc < n * TD + 20) begin
      @(negedge clk);
      cyc++;
      if (sw.tick) seen++;
    end
    chk("tick_budget", 16'(seen), 16'(n));
  endtask

  task automatic after_tick();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic count_ticks(input int c,
                             output int t);
    t = 0;
    for (int i = 0; i < c; i++) begin
      @(negedge clk);
      if (sw.tick) t++;
    end
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0,  1, 16'h0000, 1, 0, 0};
    tbl[1]  = '{0, 0, 0, 38, 16'h0010, 1, 0, 0};
    tbl[2]  = '{0, 0, 1,  4, 16'h0011, 1, 1, 0};
    tbl[3]  = '{0, 1, 0,  8, 16'h0011, 1, 1, 0};
    tbl[4]  = '{0, 0, 1,  3, 16'h0016, 1, 0, 0};
    tbl[5]  = '{1, 0, 0,  5, 16'h0017, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 20, 16'h0017, 0, 0, 0};
    tbl[7]  = '{1, 0, 0,  5, 16'h0018, 1, 0, 0};
    tbl[8]  = '{1, 0, 1,  4, 16'h0019, 0, 0, 0};
    tbl[9]  = '{1, 1, 0,  2, 16'h0000, 0, 0, 0};
    tbl[10] = '{0, 0, 1,  3, 16'h0000, 0, 0, 0};
    tbl[11] = '{0, 1, 0,  1, 16'h0000, 0, 0, 0};

    sw.btn_start_stop = 1'b0;
    sw.btn_reset      = 1'b0;
    sw.btn_lap        = 1'b0;
    clr = 1'b1;
    #2;
    chk("rst_disp", sw.disp_bcd, 16'h0000);
    chk("rst_run", 16'(sw.running), 16'd0);
    chk("rst_lap", 16'(sw.lap_active), 16'd0);
    chk("rst_ovf", 16'(sw.overflow), 16'd0);
    chk("rst_tick", 16'(sw.tick), 16'd0);
    #10;
    clr = 1'b0;

    for (int v = 0; v < 12; v++) begin
      press(tbl[v].ss, tbl[v].rst, tbl[v].lap);
      repeat (tbl[v].w) @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_disp", v),
          sw.disp_bcd, tbl[v].disp);
      chk($sformatf("v%0d_run", v),
          16'(sw.running), 16'(tbl[v].run));
      chk($sformatf("v%0d_lap", v),
          16'(sw.lap_active), 16'(tbl[v].lapa));
      chk($sformatf("v%0d_ovf", v),
          16'(sw.overflow), 16'(tbl[v].ovf));
    end

    press(1, 0, 0);
    @(posedge clk);
    count_ticks(40, tk);
    chk("ticks_40cyc", 16'(tk), 16'd10);
    press(1, 0, 0);
    @(posedge clk);
    count_ticks(20, tk);
    chk("ticks_paused", 16'(tk), 16'd0);
    press(0, 1, 0);

    press(1, 0, 0);
    wait_ticks(9);
    after_tick();
    chk("c_0009", sw.disp_bcd, 16'h0009);
    wait_ticks(1);
    after_tick();
    chk("c_0010", sw.disp_bcd, 16'h0010);
    wait_ticks(89);
    after_tick();
    chk("c_0099", sw.disp_bcd, 16'h0099);
    wait_ticks(1);
    after_tick();
    chk("c_0100", sw.disp_bcd, 16'h0100);
    wait_ticks(899);
    after_tick();
    chk("c_0999", sw.disp_bcd, 16'h0999);
    wait_ticks(1);
    after_tick();
    chk("c_1000", sw.disp_bcd, 16'h1000);
    wait_ticks(234);
    after_tick();
    chk("c_1234", sw.disp_bcd, 16'h1234);

    #1;
    clr = 1'b1;
    #1;
    chk("clr_disp", sw.disp_bcd, 16'h0000);
    chk("clr_run", 16'(sw.running), 16'd0);
    chk("clr_ovf", 16'(sw.overflow), 16'd0);
    chk("clr_tick", 16'(sw.tick), 16'd0);
    #1;
    clr = 1'b0;

    press(1, 0, 0);
    wait_ticks(1);
    after_tick();
    chk("restart", sw.disp_bcd, 16'h0001);
    wait_ticks(9998);
    after_tick();
    chk("o_9999", sw.disp_bcd, 16'h9999);
    chk("o_pre_ovf", 16'(sw.overflow), 16'd0);
    wait_ticks(1);
    after_tick();
    chk("o_disp", sw.disp_bcd, 16'h9999);
    chk("o_ovf", 16'(sw.overflow), 16'd1);
    chk("o_run", 16'(sw.running), 16'd0);
    count_ticks(10, tk);
    chk("o_noticks", 16'(tk), 16'd0);
    press(1, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("o_ss_run", 16'(sw.running), 16'd0);
    chk("o_ss_disp", sw.disp_bcd, 16'h9999);
    press(0, 1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("o_rst_disp", sw.disp_bcd, 16'h0000);
    chk("o_rst_ovf", 16'(sw.overflow), 16'd0);
    chk("o_rst_run", 16'(sw.running), 16'd0);

    @(posedge clk);
    #1;
    sw.btn_start_stop = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    sw.btn_start_stop = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("hold_run", 16'(sw.running), 16'd1);
    chk("hold_lap", 16'(sw.lap_active), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
